// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
//   rst_seq_state_e : sequencer FSM states (HOLD, RELEASE, RUN)
//   CauseBit*       : bit positions inside the sticky reset-cause register
//   rst_cause_t     : 4-bit reset-cause vector {wdog, sw, ndm, por}
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_e;

    localparam int unsigned CauseBitPor  = 0;
    localparam int unsigned CauseBitNdm  = 1;
    localparam int unsigned CauseBitSw   = 2;
    localparam int unsigned CauseBitWdog = 3;

    typedef logic [3:0] rst_cause_t;

    // Cause value held while power-on reset is active.
    localparam rst_cause_t CauseReset = 4'b0001;

endpackage

// File: rtl/rst_req_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit request.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, flops clear to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output, SyncStages cycles of latency
module rst_req_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] sync_r;

    // Shift chain: the input enters at bit 0 and leaves at the top bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r <= {SyncStages{1'b0}};
        end else begin
            sync_r <= {sync_r[SyncStages-2:0], d_i};
        end
    end

    assign q_o = sync_r[SyncStages-1];

endmodule

// File: rtl/rst_seq_mgr.sv
// Reset sequencer: drives NumDomains active-low domain resets from POR and
// three runtime request sources, releasing domains one at a time in
// ascending order with programmable hold and gap times.
//   clk_i           : clock
//   rst_i           : power-on reset, asynchronous active-high
//   ndmreset_req_i  : debug ndmreset level request
//   ndm_mask_i      : domains affected by ndmreset (bit 0 ignored)
//   sw_rst_req_i    : software request, affects domains 1..N-1
//   wdog_rst_req_i  : asynchronous watchdog request, affects domains 1..N-1
//   cause_clr_i     : pulse clearing the sticky cause register
//   rst_domain_no   : active-low domain resets
//   rst_cause_o     : sticky cause {wdog, sw, ndm, por}
//   busy_o          : high while holding or releasing
module rst_seq_mgr
    import rst_seq_pkg::*;
#(
    parameter int NumDomains = 4,
    parameter int HoldCycles = 32,
    parameter int ReleaseGap = 16,
    parameter int SyncStages = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ndmreset_req_i,
    input  logic [NumDomains-1:0] ndm_mask_i,
    input  logic                  sw_rst_req_i,
    input  logic                  wdog_rst_req_i,
    input  logic                  cause_clr_i,
    output logic [NumDomains-1:0] rst_domain_no,
    output rst_cause_t            rst_cause_o,
    output logic                  busy_o
);

    if (NumDomains < 1 || NumDomains > 16) begin : g_bad_domains
        $fatal(1, "rst_seq_mgr: NumDomains must be 1..16");
    end
    if (HoldCycles < 1) begin : g_bad_hold
        $fatal(1, "rst_seq_mgr: HoldCycles must be >= 1");
    end
    if (ReleaseGap < 1) begin : g_bad_gap
        $fatal(1, "rst_seq_mgr: ReleaseGap must be >= 1");
    end
    if (SyncStages < 2) begin : g_bad_sync
        $fatal(1, "rst_seq_mgr: SyncStages must be >= 2");
    end

    localparam int MaxCnt = (HoldCycles > ReleaseGap) ? HoldCycles : ReleaseGap;
    localparam int CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    localparam logic [CntW-1:0]       HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0]       GapLast  = CntW'(ReleaseGap - 1);
    localparam logic [CntW-1:0]       CntOne   = CntW'(1);
    localparam logic [NumDomains-1:0] AonMask  = NumDomains'(1);
    localparam logic [NumDomains-1:0] AllOnes  = {NumDomains{1'b1}};
    localparam logic [NumDomains-1:0] AllZeros = {NumDomains{1'b0}};

    rst_seq_state_e        state_r, state_nxt_s;
    logic [CntW-1:0]       cnt_r, cnt_nxt_s;
    logic [NumDomains-1:0] pending_r, pending_nxt_s;
    logic [NumDomains-1:0] rst_no_r, rst_no_nxt_s;
    rst_cause_t            cause_r, cause_nxt_s, cause_set_s;
    logic                  busy_r, busy_nxt_s;

    logic                  wdog_sync_s;
    logic [NumDomains-1:0] ndm_set_s, sw_set_s, wdog_set_s, req_set_s;
    logic                  req_any_s;
    logic [NumDomains-1:0] low_oh_s, rel_pending_s;

    rst_req_sync #(
        .SyncStages (SyncStages)
    ) u_wdog_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (wdog_rst_req_i),
        .q_o   (wdog_sync_s)
    );

    // Per-source affected sets; the always-on domain 0 is never included.
    always_comb begin
        ndm_set_s  = AllZeros;
        sw_set_s   = AllZeros;
        wdog_set_s = AllZeros;
        if (ndmreset_req_i) begin
            ndm_set_s = ndm_mask_i & ~AonMask;
        end else begin
            ndm_set_s = AllZeros;
        end
        if (sw_rst_req_i) begin
            sw_set_s = ~AonMask;
        end else begin
            sw_set_s = AllZeros;
        end
        if (wdog_sync_s) begin
            wdog_set_s = ~AonMask;
        end else begin
            wdog_set_s = AllZeros;
        end
    end

    assign req_set_s = ndm_set_s | sw_set_s | wdog_set_s;
    assign req_any_s = |req_set_s;

    // A source only counts as accepted when its affected set is non-empty.
    always_comb begin
        cause_set_s               = 4'b0000;
        cause_set_s[CauseBitNdm]  = |ndm_set_s;
        cause_set_s[CauseBitSw]   = |sw_set_s;
        cause_set_s[CauseBitWdog] = |wdog_set_s;
    end

    // Lowest pending domain as a one-hot (isolate lowest set bit).
    assign low_oh_s      = pending_r & (~pending_r + NumDomains'(1));
    assign rel_pending_s = pending_r & ~low_oh_s;

    // Next-state, counter, pending set and domain outputs.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pending_nxt_s = pending_r;
        rst_no_nxt_s  = rst_no_r;
        if (req_any_s) begin
            // Any accepted request re-enters HOLD from scratch.
            state_nxt_s   = HOLD;
            cnt_nxt_s     = {CntW{1'b0}};
            pending_nxt_s = pending_r | req_set_s;
            rst_no_nxt_s  = rst_no_r & ~req_set_s;
        end else begin
            case (state_r)
                HOLD, RELEASE: begin
                    if ((state_r == HOLD && cnt_r == HoldLast) ||
                        (state_r == RELEASE && cnt_r == GapLast)) begin
                        cnt_nxt_s     = {CntW{1'b0}};
                        pending_nxt_s = rel_pending_s;
                        rst_no_nxt_s  = rst_no_r | low_oh_s;
                        if (rel_pending_s == AllZeros) begin
                            state_nxt_s = RUN;
                        end else begin
                            state_nxt_s = RELEASE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CntOne;
                    end
                end
                RUN: begin
                    cnt_nxt_s = {CntW{1'b0}};
                end
                default: begin
                    state_nxt_s   = HOLD;
                    cnt_nxt_s     = {CntW{1'b0}};
                    pending_nxt_s = AllOnes;
                    rst_no_nxt_s  = AllZeros;
                end
            endcase
        end
    end

    // Busy tracks the next state so it drops on the last release edge.
    always_comb begin
        if (state_nxt_s == RUN) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = 1'b1;
        end
    end

    // Sticky cause: clear first, then OR in accepted sources so set wins.
    always_comb begin
        if (cause_clr_i) begin
            cause_nxt_s = cause_set_s;
        end else begin
            cause_nxt_s = cause_r | cause_set_s;
        end
    end

    // State and output registers with asynchronous power-on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= HOLD;
            cnt_r     <= {CntW{1'b0}};
            pending_r <= AllOnes;
            rst_no_r  <= AllZeros;
            cause_r   <= CauseReset;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pending_r <= pending_nxt_s;
            rst_no_r  <= rst_no_nxt_s;
            cause_r   <= cause_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign rst_domain_no = rst_no_r;
    assign rst_cause_o   = cause_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_rst_seq_mgr.sv
// Directed self-checking bench for rst_seq_mgr with N=4, HoldCycles=4,
// ReleaseGap=2, SyncStages=2.
module tb_rst_seq_mgr;

    logic       clk = 1'b0;
    logic       rst;
    logic       ndmreset_req;
    logic [3:0] ndm_mask;
    logic       sw_rst_req;
    logic       wdog_rst_req;
    logic       cause_clr;
    logic [3:0] rst_domain_n;
    logic [3:0] rst_cause;
    logic       busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    rst_seq_mgr #(
        .NumDomains (4),
        .HoldCycles (4),
        .ReleaseGap (2),
        .SyncStages (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ndmreset_req_i (ndmreset_req),
        .ndm_mask_i     (ndm_mask),
        .sw_rst_req_i   (sw_rst_req),
        .wdog_rst_req_i (wdog_rst_req),
        .cause_clr_i    (cause_clr),
        .rst_domain_no  (rst_domain_n),
        .rst_cause_o    (rst_cause),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Domain pattern k edges after POR release: domains rise at 4/6/8/10.
    function automatic logic [3:0] por_exp(input int k);
        logic [3:0] e;
        e = 4'b0000;
        if (k >= 4)  e[0] = 1'b1;
        if (k >= 6)  e[1] = 1'b1;
        if (k >= 8)  e[2] = 1'b1;
        if (k >= 10) e[3] = 1'b1;
        return e;
    endfunction

    // Domain pattern k edges after a sw request edge: 1/2/3 rise at 4/6/8.
    function automatic logic [3:0] sw_exp(input int k);
        logic [3:0] e;
        e = 4'b0001;
        if (k >= 4) e[1] = 1'b1;
        if (k >= 6) e[2] = 1'b1;
        if (k >= 8) e[3] = 1'b1;
        return e;
    endfunction

    // Release rst_i and follow the full POR sequence.
    task automatic por_seq(input string tag);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk({tag, "_dom"}, 32'(rst_domain_n), 32'(por_exp(k)));
            chk({tag, "_busy"}, 32'(busy), (k < 10) ? 32'd1 : 32'd0);
            chk({tag, "_cause"}, 32'(rst_cause), 32'h1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        ndmreset_req = 1'b0;
        ndm_mask     = 4'b0000;
        sw_rst_req   = 1'b0;
        wdog_rst_req = 1'b0;
        cause_clr    = 1'b0;
        #1;
        chk("rst_dom", 32'(rst_domain_n), 32'h0);
        chk("rst_cause", 32'(rst_cause), 32'h1);
        chk("rst_busy", 32'(busy), 32'd1);
        tick();
        tick();
        chk("rst_dom_clk", 32'(rst_domain_n), 32'h0);

        // Power-on sequence.
        por_seq("por");

        // Empty affected set: ndm with only bit 0 in the mask is ignored.
        ndmreset_req = 1'b1;
        ndm_mask     = 4'b0001;
        tick();
        ndmreset_req = 1'b0;
        chk("ndm_empty_dom", 32'(rst_domain_n), 32'hF);
        chk("ndm_empty_cause", 32'(rst_cause), 32'h1);
        chk("ndm_empty_busy", 32'(busy), 32'd0);

        // ndmreset held 10 cycles with mask 1011: domains 1 and 3 only.
        ndmreset_req = 1'b1;
        ndm_mask     = 4'b1011;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("ndm_hold_dom", 32'(rst_domain_n), 32'h5);
        end
        ndmreset_req = 1'b0;
        chk("ndm_cause", 32'(rst_cause), 32'h3);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("ndm_rel_dom", 32'(rst_domain_n),
                (k < 4) ? 32'h5 : ((k < 6) ? 32'h7 : 32'hF));
            chk("ndm_rel_busy", 32'(busy), (k < 6) ? 32'd1 : 32'd0);
        end

        // Same-cycle clear and sw request from cause 0011.
        cause_clr  = 1'b1;
        sw_rst_req = 1'b1;
        tick();
        cause_clr  = 1'b0;
        sw_rst_req = 1'b0;
        chk("clr_sw_cause", 32'(rst_cause), 32'h4);
        chk("sw_dom0", 32'(rst_domain_n), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("sw_dom", 32'(rst_domain_n), 32'(sw_exp(k)));
            chk("sw_busy", 32'(busy), (k < 8) ? 32'd1 : 32'd0);
        end

        // Watchdog pulse during RELEASE after domain 1 has risen.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        chk("wd_pre_dom", 32'(rst_domain_n), 32'h3);
        wdog_rst_req = 1'b1;
        for (int k = 5; k <= 17; k++) begin
            tick();
            if (k == 7) begin
                wdog_rst_req = 1'b0;
            end
            chk("wd_dom", 32'(rst_domain_n),
                (k == 5) ? 32'h3 : (k == 6) ? 32'h7 : (k < 13) ? 32'h1 :
                (k < 15) ? 32'h3 : (k < 17) ? 32'h7 : 32'hF);
            chk("wd_busy", 32'(busy), (k < 17) ? 32'd1 : 32'd0);
        end
        chk("wd_cause", 32'(rst_cause), 32'hC);

        // Asynchronous POR in the middle of RELEASE.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
        end
        chk("mid_pre_dom", 32'(rst_domain_n), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_dom", 32'(rst_domain_n), 32'h0);
        chk("async_cause", 32'(rst_cause), 32'h1);
        chk("async_busy", 32'(busy), 32'd1);
        tick();
        tick();
        por_seq("repor");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
